// File: rtl/dispatch_queue_2pusher.sv
// dispatch_queue_2pusher
//   In-order FIFO with two enqueue lanes and one dequeue port.
//   Lane 0 is the older lane. Lane 1 is accepted only together with lane 0,
//   and its entry goes in directly behind lane 0's entry.
//   There is no bypass path: an entry appears on out_* one cycle after it is accepted.
//
// Ports
//   sys_clk            clock, rising edge
//   sys_rst_n          asynchronous active-low reset (clears head/tail/count)
//   in0_valid/in0_data lane 0 enqueue request and payload
//   in1_valid/in1_data lane 1 enqueue request and payload
//   in0_ready          at least one free entry (from registered count)
//   in1_ready          at least two free entries (from registered count)
//   out_valid/out_data head entry present / head payload
//   out_ready          consumer accepts the head entry
//   occupancy          registered entry count; present only when
//                      DISPATCH_QUEUE_2PUSHER_OCC_EN is defined
module dispatch_queue_2pusher #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in0_ready,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef DISPATCH_QUEUE_2PUSHER_OCC_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    tail1;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic       push0;
    logic       push1;
    logic       pop;
    logic [1:0] n_push;

    // The readies look only at the registered count. A dequeue in the same
    // cycle does not make room early, so out_ready has no combinational
    // path to either ready.
    assign in0_ready = (count_q != CW'(DEPTH));
    assign in1_ready = (count_q <= CW'(DEPTH - 2));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[head_q];
    assign tail1     = tail_q + PW'(1);

`ifdef DISPATCH_QUEUE_2PUSHER_OCC_EN
    assign occupancy = count_q;
`endif

    always_comb begin
        push0   = in0_valid && in0_ready;
        push1   = in1_valid && in1_ready && push0;
        pop     = out_valid && out_ready;
        n_push  = {1'b0, push0} + {1'b0, push1};
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(pop);
        mem_d   = mem_q;
        if (push0) mem_d[tail_q] = in0_data;
        if (push1) mem_d[tail1]  = in1_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; entries are only ever read after being written.
    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/dispatch_queue_2pusher.md
DISPATCH_QUEUE_2PUSHER -- requirements
Module: dispatch_queue_2pusher

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; power of two and at least 2.
REQ-003 SHALL have port sys_clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in0_valid, input, 1 bit: enqueue lane 0 (older) request.
REQ-006 SHALL have port in0_data, input, WIDTH bits: lane 0 payload.
REQ-007 SHALL have port in1_valid, input, 1 bit: enqueue lane 1 (younger) request.
REQ-008 SHALL have port in1_data, input, WIDTH bits: lane 1 payload.
REQ-009 SHALL have port in0_ready, output, 1 bit: at least 1 free entry.
REQ-010 SHALL have port in1_ready, output, 1 bit: at least 2 free entries.
REQ-011 SHALL have port out_valid, output, 1 bit: head entry present.
REQ-012 SHALL have port out_data, output, WIDTH bits: head entry payload.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts head.

Function
REQ-014 SHALL be a strict in-order FIFO: dequeue order equals acceptance order, lane 0 before lane 1 within a cycle.
REQ-015 Lane 0 fire SHALL be in0_valid && in0_ready.
REQ-016 Lane 1 fire SHALL be in1_valid && in1_ready && lane 0 fire; in1 without lane 0 fire is dropped and retried by the producer.
REQ-017 in0_ready and in1_ready SHALL be derived from the registered count only; a same-cycle dequeue does not raise ready (no combinational out_ready-to-in_ready path).
REQ-018 Dequeue fire SHALL be out_valid && out_ready; out_valid = (count != 0); out_data = storage[head].
REQ-019 out_data SHALL be don't-care when out_valid=0; the bench checks it only on dequeue fire.
REQ-020 Latency SHALL be 1 cycle: an entry accepted at edge N is visible on out_* after edge N if the queue was empty.
REQ-021 No bypass: out_valid SHALL be low in the same cycle as the first push into an empty queue.
REQ-022 Next count SHALL be count + pushes (0..2) - pop (0..1), evaluated the same cycle; push and pop may coincide, including both pushes while full-minus-2 with a pop.
REQ-023 Head and tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; lane 1 writes at tail+1 mod DEPTH.
REQ-024 count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH, and never overflow or underflow by construction.
REQ-025 Full (count=DEPTH) SHALL give in0_ready=0 and in1_ready=0.
REQ-026 count=DEPTH-1 SHALL give in0_ready=1 and in1_ready=0.
REQ-027 Empty SHALL give out_valid=0; out_ready is ignored.

Reset
REQ-028 sys_rst_n=0 SHALL immediately clear head, tail and count, independent of sys_clk.
REQ-029 During reset, outputs SHALL be out_valid=0, in0_ready=1, in1_ready=1; storage contents are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first edge after release accepts fresh pushes normally.

Configuration
REQ-031 Macro DISPATCH_QUEUE_2PUSHER_OCC_EN, when defined, SHALL add output occupancy (log2(DEPTH)+1 bits) equal to the registered count, reset value 0.
REQ-032 Without DISPATCH_QUEUE_2PUSHER_OCC_EN, the occupancy port SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Dual push after reset, DEPTH=4, out_ready=0: cycle 1 pushes 0x11/0x22, cycle 2 pushes 0x33/0x44 -> full; in0_ready=0; out_data=0x11.
REQ-034 Drain: out_ready=1 for 4 cycles -> dequeues 0x11, 0x22, 0x33, 0x44, then out_valid=0.
REQ-035 Three entries: offer 0xAA/0xBB -> only 0xAA accepted (in1_ready=0); the next dequeue sequence ends with 0xAA.
REQ-036 in1_valid=1 with in0_valid=0, data 0x77 -> nothing enqueued; count unchanged.
REQ-037 Two entries, out_ready=1, push 0x55/0x66 in the same cycle -> count becomes 3; order preserved across pointer wrap over 3 laps with an incrementing pattern.
REQ-038 Assert sys_rst_n=0 mid-stream between clock edges -> out_valid=0 immediately, both readies=1; after release, push 0x99 -> dequeued 0x99 first; occupancy tracks count when the macro is defined.
